// File: rtl/aabb_closest_hit_seq_pkg.sv
// rtl/aabb_closest_hit_seq_pkg.sv - shared ray/box/hit types and fixed-point math for the closest-hit sequencer
//
// Purpose: Fixed (signed 16.16) arithmetic helpers, Ray/AABB/HitData records,
//          and the combinational slab-method AABB hit test (aabb_hit).
// Ports:   none (package).
package aabb_closest_hit_seq_pkg;

  localparam int FRAC_W = 16;

  typedef logic signed [31:0] fixed_t;

  localparam fixed_t FIXED_ONE     = 32'sh0001_0000;
  localparam fixed_t FIXED_NEG_ONE = -32'sh0001_0000;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  typedef enum logic [1:0] {
    SURF_NONE,
    SURF_DIFFUSE,
    SURF_SPECULAR,
    SURF_EMISSIVE
  } surface_type_t;

  typedef logic [15:0] voxel_index_t;

  localparam voxel_index_t NULL_VOXEL_INDEX = 16'hFFFF;

  typedef struct packed {
    vec3_t        orig;
    vec3_t        dir;
    vec3_t        inv_dir;
    fixed_t       min_t;
    fixed_t       max_t;
    voxel_index_t vi;
  } ray_t;

  typedef struct packed {
    vec3_t lo;
    vec3_t hi;
  } aabb_t;

  typedef struct packed {
    logic          b_hit;
    fixed_t        t;
    voxel_index_t  vi;
    rgb8_t         color;
    surface_type_t surface_type;
    vec3_t         normal;
  } hit_data_t;

  typedef struct packed {
    logic   b_hit;
    fixed_t t;
    vec3_t  normal;
  } aabb_test_t;

  localparam hit_data_t HIT_CLEAR = '{
    b_hit:        1'b0,
    t:            '0,
    vi:           NULL_VOXEL_INDEX,
    color:        '0,
    surface_type: SURF_NONE,
    normal:       '0
  };

  function automatic logic fixed_lt(input fixed_t a, input fixed_t b);
    return a < b;
  endfunction

  function automatic fixed_t fixed_mul(input fixed_t a, input fixed_t b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return fixed_t'(p >>> FRAC_W);
  endfunction

  function automatic fixed_t vec_axis(input vec3_t v, input int i);
    case (i)
      0:       return v.x;
      1:       return v.y;
      default: return v.z;
    endcase
  endfunction

  // Slab test. The hit distance is the entry point clamped to [min_t, max_t];
  // a box touching the ray at a single point (entry == exit) counts as a hit.
  // The normal faces back along the ray on the axis that set the entry point;
  // it stays zero when min_t set the entry (origin inside the box).
  function automatic aabb_test_t aabb_hit(input ray_t ray, input aabb_t box);
    aabb_test_t res;
    fixed_t     t_enter;
    fixed_t     t_exit;
    fixed_t     t0;
    fixed_t     t1;
    fixed_t     t_near;
    fixed_t     t_far;
    logic [1:0] axis;
    t_enter = ray.min_t;
    t_exit  = ray.max_t;
    axis    = 2'd3;
    for (int i = 0; i < 3; i++) begin
      t0 = fixed_mul(vec_axis(box.lo, i) - vec_axis(ray.orig, i), vec_axis(ray.inv_dir, i));
      t1 = fixed_mul(vec_axis(box.hi, i) - vec_axis(ray.orig, i), vec_axis(ray.inv_dir, i));
      t_near = fixed_lt(t1, t0) ? t1 : t0;
      t_far  = fixed_lt(t1, t0) ? t0 : t1;
      if (fixed_lt(t_enter, t_near)) begin
        t_enter = t_near;
        axis    = 2'(i);
      end
      if (fixed_lt(t_far, t_exit)) begin
        t_exit = t_far;
      end
    end
    res.b_hit  = !fixed_lt(t_exit, t_enter);
    res.t      = t_enter;
    res.normal = '0;
    case (axis)
      2'd0:    res.normal.x = ray.dir.x[31] ? FIXED_ONE : FIXED_NEG_ONE;
      2'd1:    res.normal.y = ray.dir.y[31] ? FIXED_ONE : FIXED_NEG_ONE;
      2'd2:    res.normal.z = ray.dir.z[31] ? FIXED_ONE : FIXED_NEG_ONE;
      default: res.normal = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/closest_hit_select.sv
// rtl/closest_hit_select.sv - best-hit compare/replace for the closest-hit sequencer
//
// Purpose: decide whether a candidate hit displaces the current best hit.
// Ports:   best      - current best-hit record
//          candidate - test result for the primitive now on the read bus
//                      (b_hit already qualified by read-data validity)
//          next_best - best hit after considering candidate
//          replace   - candidate displaced best
module closest_hit_select
  import aabb_closest_hit_seq_pkg::*;
(
  input  hit_data_t best,
  input  hit_data_t candidate,
  output hit_data_t next_best,
  output logic      replace
);

  // Strict less-than: primitives arrive in ascending index order, so on an
  // equal distance the earlier (lower-index) primitive is kept.
  always_comb begin
    replace   = candidate.b_hit && (!best.b_hit || fixed_lt(candidate.t, best.t));
    next_best = replace ? candidate : best;
  end

endmodule

// File: rtl/aabb_closest_hit_seq.sv
// rtl/aabb_closest_hit_seq.sv - sequential closest-hit search of one ray over a primitive list
//
// Purpose: accept a ray, read primitives 0..num_prims-1 one per cycle, test each
//          against the ray and return the closest hit.
// Config:  AABB_SEQ_ANY_HIT_EN adds input any_hit; when set, the scan stops at
//          the first hit and reports it.
// Ports:   clk, reset (async, active high)
//          ray_valid/ray_ready, ray_in, num_prims   - ray request (sampled at accept)
//          prim_rd_en, prim_addr                    - primitive memory read
//          prim_aabb, prim_color, prim_vi, prim_st  - read data, one cycle after prim_rd_en
//          hit_valid/hit_ready, hit_out             - result
module aabb_closest_hit_seq
  import aabb_closest_hit_seq_pkg::*;
#(
  parameter int MAX_PRIMS = 64,
  parameter int ADDR_W    = $clog2(MAX_PRIMS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ray_valid,
  output logic              ray_ready,
  input  ray_t              ray_in,
  input  logic [ADDR_W:0]   num_prims,
`ifdef AABB_SEQ_ANY_HIT_EN
  input  logic              any_hit,
`endif
  output logic              prim_rd_en,
  output logic [ADDR_W-1:0] prim_addr,
  input  aabb_t             prim_aabb,
  input  rgb8_t             prim_color,
  input  voxel_index_t      prim_vi,
  input  surface_type_t     prim_st,
  output logic              hit_valid,
  input  logic              hit_ready,
  output hit_data_t         hit_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(MAX_PRIMS);

  state_t            state_q;
  state_t            state_d;
  ray_t              ray_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_valid_q;
  hit_data_t         best_q;
  hit_data_t         best_next;
  hit_data_t         candidate;
  aabb_test_t        test;
  logic              replace;
  logic              accept;
  logic              last_issue;
  logic              cand_valid;
  logic              stop_hit;
  logic [ADDR_W:0]   num_clamped;

  assign num_clamped = (num_prims > MAX_COUNT) ? MAX_COUNT : num_prims;
  assign accept      = ray_valid && ray_ready;
  assign last_issue  = ({1'b0, addr_q} + (ADDR_W + 1)'(1)) == count_q;
  assign prim_addr   = addr_q;
  assign hit_out     = best_q;

`ifdef AABB_SEQ_ANY_HIT_EN
  logic any_q;
  logic stop_q;

  // Once the first hit is taken, read data still in flight is ignored.
  assign stop_hit   = any_q && replace;
  assign cand_valid = rd_valid_q && !stop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_q  <= 1'b0;
      stop_q <= 1'b0;
    end else if (accept) begin
      any_q  <= any_hit;
      stop_q <= 1'b0;
    end else if (stop_hit) begin
      stop_q <= 1'b1;
    end
  end
`else
  assign stop_hit   = 1'b0;
  assign cand_valid = rd_valid_q;
`endif

  always_comb begin
    test                   = aabb_hit(ray_q, prim_aabb);
    candidate.b_hit        = cand_valid && test.b_hit;
    candidate.t            = test.t;
    candidate.vi           = prim_vi;
    candidate.color        = prim_color;
    candidate.surface_type = prim_st;
    candidate.normal       = test.normal;
  end

  closest_hit_select u_select (
    .best      (best_q),
    .candidate (candidate),
    .next_best (best_next),
    .replace   (replace)
  );

  always_comb begin
    state_d    = state_q;
    ray_ready  = 1'b0;
    prim_rd_en = 1'b0;
    hit_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        ray_ready = 1'b1;
        if (ray_valid) begin
          state_d = (num_clamped == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        prim_rd_en = 1'b1;
        if (stop_hit || last_issue) begin
          state_d = DRAIN;
        end
      end
      // One cycle for the final read's data to be tested.
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        hit_valid = 1'b1;
        if (hit_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ray_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      best_q     <= HIT_CLEAR;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= prim_rd_en;
      if (accept) begin
        ray_q   <= ray_in;
        count_q <= num_clamped;
        addr_q  <= '0;
        best_q  <= HIT_CLEAR;
      end else begin
        if (prim_rd_en) begin
          addr_q <= addr_q + ADDR_W'(1);
        end
        best_q <= best_next;
      end
    end
  end

endmodule

// File: doc/aabb_closest_hit_seq.md
AABB_CLOSEST_HIT_SEQ -- requirements
Module: aabb_closest_hit_seq

Interface
REQ-001 SHALL have parameter MAX_PRIMS, default 64, meaning the maximum primitive count per ray.
REQ-002 SHALL have parameter ADDR_W, default $clog2(MAX_PRIMS), meaning the primitive address width.
REQ-003 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port ray_valid  in  1  ray request present.
REQ-006 SHALL have port ray_ready  out  1  sequencer idle, request accepted this cycle if ray_valid.
REQ-007 SHALL have port ray_in  in  Ray  ray to trace (Orig, Dir, InvDir, MinT, MaxT, VI).
REQ-008 SHALL have port num_prims  in  ADDR_W+1  primitive count, sampled at accept, 0..MAX_PRIMS.
REQ-009 SHALL have port prim_rd_en  out  1  primitive memory read strobe.
REQ-010 SHALL have port prim_addr  out  ADDR_W  primitive index being read.
REQ-011 SHALL have port prim_aabb, prim_color, prim_vi, prim_st  in  AABB/RGB8/VOXEL_INDEX/SurfaceType  read data, valid exactly 1 cycle after prim_rd_en.
REQ-012 SHALL have port hit_valid  out  1  result available.
REQ-013 SHALL have port hit_ready  in  1  consumer accepts result.
REQ-014 SHALL have port hit_out  out  HitData  closest hit (bHit, T, VI, Color, SurfaceType, Normal).

Function
REQ-015 SHALL use states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on ray_valid&&ray_ready with num_prims>0; IDLE->DRAIN when num_prims==0.
REQ-016 SHALL register ray_in and num_prims at accept; later ray_in changes SHALL have no effect.
REQ-017 SHALL, in ISSUE, assert prim_rd_en every cycle with prim_addr = 0,1,...,num_prims-1 (one per cycle), then enter DRAIN.
REQ-018 SHALL feed returned primitive data plus latched ray to one combinational AABB closest-hit test (AABBHit) the cycle data is valid.
REQ-019 SHALL keep a best-hit register: replace when test bHit==1 and (best.bHit==0 or test.T < best.T, signed fixed compare); equal T SHALL keep the lower index.
REQ-020 SHALL clear the best-hit register at accept: bHit=0, VI=NULL_VOXEL_INDEX.
REQ-021 SHALL leave DRAIN one cycle after last data accepted, entering DONE; hit_valid first high cycle = accept cycle + num_prims + 2 (num_prims==0: accept + 2).
REQ-022 SHALL hold hit_valid and hit_out stable in DONE until hit_ready; DONE->IDLE on hit_valid&&hit_ready.
REQ-023 SHALL drive ray_ready=1 only in IDLE; no ray is accepted in the same cycle a result is consumed.
REQ-024 SHALL drive prim_rd_en=0 outside ISSUE; prim_addr value is don't-care when prim_rd_en=0.
REQ-025 SHALL clamp num_prims > MAX_PRIMS to MAX_PRIMS.

Reset
REQ-026 SHALL on reset (any cycle, including mid-ISSUE/DRAIN/DONE) force state IDLE, ray_ready=1 after release, prim_rd_en=0, prim_addr=0, hit_valid=0, hit_out.bHit=0, hit_out.VI=NULL_VOXEL_INDEX; in-flight ray discarded, no result emitted.

Configuration
REQ-027 SHALL, with AABB_SEQ_ANY_HIT_EN defined, add input any_hit (sampled at accept); when set, first test with bHit=1 SHALL stop issuing (prim_rd_en low next cycle), enter DRAIN, report that hit (normal computation not required), in-flight later data ignored.
REQ-028 SHALL, without AABB_SEQ_ANY_HIT_EN, have no any_hit port and always scan all num_prims primitives.

Structure
REQ-029 SHALL take Ray, AABB, HitData, RGB8, SurfaceType, VOXEL_INDEX, NULL_VOXEL_INDEX and Fixed compare helpers from the shared types/math headers; state enum local to the module.
REQ-030 SHALL place the best-hit compare/replace logic in one sub-module closest_hit_select (inputs best, candidate; output next best, replace flag).

Verification
REQ-031 SHALL cover: 3 prims, hits at T=5.0, 2.0, 7.0 -> hit_out.T=2.0, VI=prim1, hit_valid at accept+5.
REQ-032 SHALL cover: num_prims=0 -> hit_valid at accept+2, bHit=0, VI=NULL, prim_rd_en never high.
REQ-033 SHALL cover: 2 prims, equal T=3.0 -> VI=prim0; 4 misses -> bHit=0.
REQ-034 SHALL cover: hit_ready low 10 cycles in DONE -> hit_out stable, ray_ready=0, ray_valid ignored throughout.
REQ-035 SHALL cover: reset asserted at ISSUE index 3 of 8 -> next cycle hit_valid=0, prim_rd_en=0; new ray after release completes normally.
REQ-036 SHALL cover (AABB_SEQ_ANY_HIT_EN): any_hit=1, 8 prims, first hit at index 2 -> last prim_addr issued <=3, result VI=prim2.
